// File: rtl/nfca_pkg.sv
// Shared types and helpers for the ISO14443-A PICC transmit path: state encoding,
// default bit/subcarrier timing at 81.36 MHz, and the odd-parity function.
package nfca_pkg;

  localparam int unsigned HALF_BIT_CYC_DEF = 384;
  localparam int unsigned SUBC_HALF_DEF    = 48;

  typedef enum logic [2:0] {
    StIdle,
    StSof,
    StData,
    StPar,
    StEof
  } state_e;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/nfca_bit_timer.sv
// Half-bit and fc/16 subcarrier timing for the PICC transmitter; all counters are
// cleared by a start strobe so the SOF begins on a fresh bit and subcarrier phase.
module nfca_bit_timer #(
  parameter int unsigned HALF_BIT_CYC = 384,
  parameter int unsigned SUBC_HALF    = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic half_end,
  output logic bit_end,
  output logic second_half,
  output logic subc_on
);

  localparam int unsigned HW = $clog2(HALF_BIT_CYC);
  localparam int unsigned SW = $clog2(2 * SUBC_HALF);

  logic [HW-1:0] half_cnt_q;
  logic [SW-1:0] subc_cnt_q;
  logic          second_half_q;

  assign half_end    = (half_cnt_q == HW'(HALF_BIT_CYC - 1));
  assign bit_end     = half_end & second_half_q;
  assign second_half = second_half_q;
  assign subc_on     = (subc_cnt_q < SW'(SUBC_HALF));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      half_cnt_q    <= '0;
      subc_cnt_q    <= '0;
      second_half_q <= 1'b0;
    end else begin
      half_cnt_q <= half_end ? '0 : half_cnt_q + 1'b1;
      subc_cnt_q <= (subc_cnt_q == SW'(2 * SUBC_HALF - 1)) ? '0 : subc_cnt_q + 1'b1;
      if (half_end) second_half_q <= ~second_half_q;
    end
  end

endmodule

// File: rtl/nfca_picc_tx.sv
// ISO14443-A card-side transmitter: byte stream to Manchester-coded, subcarrier load modulation.
// Define NFCA_PICC_TX_PARITY_EN to insert an odd parity bit after every full 8-bit byte.
module nfca_picc_tx
  import nfca_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYC = HALF_BIT_CYC_DEF,
  parameter int unsigned SUBC_HALF    = SUBC_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tlast,
  input  logic [2:0] tx_tbits,
  output logic       load_mod,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  logic       buf_full_q;
  logic [7:0] buf_data_q;
  logic       buf_last_q;
  logic [2:0] buf_bits_q;

  state_e     state_q;
  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] byte_len_q;
  logic       cur_last_q;
  logic       par_q;
  logic       busy_q, done_q, underrun_q;

  logic       unused_half_end;
  logic       bit_end, second_half, subc_on;
  logic       tmr_start, accept, load, byte_end, par_next, boundary;
  logic [3:0] buf_len;
  logic       tx_bit, mod_active;

  assign tx_tready = ~buf_full_q & ~rst;
  assign accept    = tx_tvalid & tx_tready;
  assign tmr_start = (state_q == StIdle) & buf_full_q;
  assign buf_len   = (buf_last_q && buf_bits_q != 3'd0) ? {1'b0, buf_bits_q} : 4'd8;
  assign byte_end  = bit_end & (state_q == StData) & ({1'b0, bit_cnt_q} == byte_len_q - 4'd1);

`ifdef NFCA_PICC_TX_PARITY_EN
  assign par_next = (byte_len_q == 4'd8);
`else
  assign par_next = 1'b0;
`endif

  // Last cycle of a byte's final bit (or its parity bit): the next byte is due now.
  assign boundary = (byte_end & ~par_next) | ((state_q == StPar) & bit_end);
  assign load     = tmr_start | (boundary & ~cur_last_q & buf_full_q);

  nfca_bit_timer #(
    .HALF_BIT_CYC (HALF_BIT_CYC),
    .SUBC_HALF    (SUBC_HALF)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (tmr_start),
    .half_end    (unused_half_end),
    .bit_end     (bit_end),
    .second_half (second_half),
    .subc_on     (subc_on)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
      buf_bits_q <= '0;
    end else begin
      if (load) buf_full_q <= 1'b0;
      if (accept) begin
        buf_full_q <= 1'b1;
        buf_data_q <= tx_tdata;
        buf_last_q <= tx_tlast;
        buf_bits_q <= tx_tbits;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_len_q <= 4'd8;
      cur_last_q <= 1'b0;
      par_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (load) begin
        shreg_q    <= buf_data_q;
        bit_cnt_q  <= '0;
        byte_len_q <= buf_len;
        cur_last_q <= buf_last_q;
        par_q      <= odd_parity(buf_data_q);
      end
      unique case (state_q)
        StIdle: begin
          if (buf_full_q) begin
            state_q <= StSof;
            busy_q  <= 1'b1;
          end
        end
        StSof: if (bit_end) state_q <= StData;
        StData, StPar: begin
          if (boundary) begin
            if (cur_last_q) begin
              state_q <= StEof;
            end else if (buf_full_q) begin
              state_q <= StData;
            end else begin
              underrun_q <= 1'b1;
              state_q    <= StEof;
            end
          end else if (byte_end) begin
            state_q <= StPar;
          end else if (bit_end) begin
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        StEof: begin
          if (bit_end) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    tx_bit = 1'b1;
    if (state_q == StData) tx_bit = shreg_q[0];
    else if (state_q == StPar) tx_bit = par_q;
  end

  // Logic 1 modulates the first half, logic 0 the second half.
  assign mod_active = (state_q == StSof) | (state_q == StData) | (state_q == StPar);
  assign load_mod   = mod_active & (tx_bit ^ second_half) & subc_on;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule
